uart_rx_mmio: RTL and testbench
===============================

Name: uart_rx_mmio

Overview:
- 8N1 UART receiver with an 8-entry receive FIFO and a memory-mapped register slave on the CPU data bus.
- Counterpart of the existing TX path: the same sys_bus decodes a uart_rx slot and drives the strobes.
- The CPU polls status, or reacts to rx_irq, and pops bytes by reading the DATA register.
- Line sampled at mid-bit using a counter derived from CLK_FREQ/BAUD_RATE.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD_RATE, 115200, line rate; BIT_CNT = CLK_FREQ/BAUD_RATE (truncated, 434); HALF_CNT = BIT_CNT/2 (217).
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_pin  in  1  asynchronous serial input, idle high
- bus_addr  in  32  CPU byte address; only bits [3:2] decoded
- bus_ren  in  1  one-cycle read strobe for this slave
- bus_wen  in  1  one-cycle write strobe for this slave
- bus_wdata  in  32  write data
- mmio_rdata  out  32  combinational read data for the current bus_addr
- rx_irq  out  1  high while the FIFO is non-empty

Behaviour:
- Reset values:
  - Synchronizer flops = 1.
  - FSM = IDLE; bit counter and shift register = 0.
  - FIFO empty; overrun and frame_err = 0.
  - rx_irq = 0; mmio_rdata = 0.
- Input sync: rx_pin passes through 2 flops (rx_s). All logic uses rx_s only.
- IDLE: rx_s == 0 -> START, counter cleared.
- START: at counter == HALF_CNT-1:
  - rx_s == 0 -> DATA, counter = 0, bit index = 0.
  - rx_s == 1 -> IDLE (glitch rejected, nothing pushed).
- DATA: at counter == BIT_CNT-1, sample rx_s into the shift register LSB-first and clear the counter. After the 8th sample -> STOP.
- STOP: at counter == BIT_CNT-1:
  - rx_s == 1 -> push byte, go to IDLE.
  - rx_s == 0 -> set frame_err, discard byte, go to BREAK.
- BREAK: wait for rx_s == 1, then IDLE. A held-low line never re-triggers.
- Push is a one-cycle pulse in the cycle after the stop sample.
- Push while full and no pop in the same cycle -> byte dropped, overrun set, FIFO contents unchanged.
- Registers (offset = bus_addr[3:2]):
  - 0 DATA, read: {24'b0, head byte}; reads 0 when empty.
  - 1 STATUS, read: bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bits[7:4] = occupancy count (saturates at FIFO_DEPTH, 4 bits wide), rest 0.
  - 1 STATUS, write: write-1-to-clear for bits 2 and 3; other bits ignored.
  - 2, 3: read 0; writes ignored.
- Pop: bus_ren && offset 0 && not empty.
  - mmio_rdata shows the head in that same cycle.
  - Pointer advances at the clock edge.
  - bus_ren on an empty FIFO has no effect.
- Simultaneous push and pop:
  - FIFO full -> both occur, no overrun, count unchanged.
  - FIFO empty -> pop ignored, push occurs.
- Simultaneous sticky set and W1C clear in the same cycle -> set wins.
- Pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.
- rx_irq is registered from the FIFO state: it rises 1 cycle after the first push and falls 1 cycle after the last pop.
- Reset asserted mid-frame: all state is cleared immediately; the partial byte is lost and nothing is pushed.

Decomposition:
- Shared package uart_pkg:
  - Register offsets (DATA = 0, STATUS = 1).
  - STATUS bit indices.
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - BIT_CNT/HALF_CNT computation function, shared with the TX side.
- One sub-module, uart_rx_fifo: synchronous FIFO with push/pop/full/empty/count, head visible combinationally. Reusable later for a TX FIFO.

Test Plan:
- Serial 0x55 at 115200 baud (434 clk/bit) -> STATUS reads 0x11; DATA reads 0x00000055; STATUS then reads 0x00; rx_irq falls 1 cycle after the pop.
- 100-cycle low glitch on an idle line -> FSM returns to IDLE, STATUS stays 0x00, no push.
- Frame 0xA3 with stop bit = 0, line then high -> STATUS bit3 = 1, count 0. Write 0x8 to STATUS -> reads 0x00.
- 9 back-to-back bytes 0x01..0x09, no reads -> STATUS = 0x87. Eight DATA reads return 0x01..0x08, then empty.
- FIFO full; DATA read issued in the same cycle as the next push -> read returns the oldest byte, no overrun, count stays 8.
- rst_n low for 5 cycles during bit 4 of a frame -> STATUS 0x00, rx_irq 0. The next complete frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS bit layout, receiver states
// and the baud divider arithmetic used by both the RX and TX paths.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned bit_cnt(input int unsigned clk_freq,
                                          input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned half_cnt(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return bit_cnt(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with the head entry visible combinationally; a push into a
// full FIFO succeeds only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with mid-bit sampling, a receive FIFO and a small
// memory-mapped register slave (DATA pops, STATUS with W1C sticky errors).
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin,
  input  logic [31:0] bus_addr,
  input  logic        bus_ren,
  input  logic        bus_wen,
  input  logic [31:0] bus_wdata,
  output logic [31:0] mmio_rdata,
  output logic        rx_irq
);
  localparam int unsigned BIT_CNT  = bit_cnt(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_CNT = half_cnt(CLK_FREQ, BAUD_RATE);
  localparam int          CW       = $clog2(BIT_CNT);
  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_CNT - 1);

  logic             sync1_q, sync2_q, rx_s;
  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             frame_set;
  logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic             irq_q;

  logic [1:0]       offset;
  logic             pop, w1c;
  logic [7:0]       fifo_head;
  logic             fifo_empty, fifo_full, fifo_drop;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      count_ext, status;
  logic [3:0]       count4;
  logic             unused_ok;

  assign rx_s      = sync2_q;
  assign offset    = bus_addr[3:2];
  assign pop       = bus_ren && (offset == REG_DATA);
  assign w1c       = bus_wen && (offset == REG_STATUS);
  assign rx_irq    = irq_q;
  assign unused_ok = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:4], bus_wdata[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= rx_pin;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_q       <= !fifo_empty;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A line held low after a bad stop bit must not start a new frame.
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear first so a same-cycle set wins.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (w1c && bus_wdata[STAT_OVERRUN])   overrun_d   = 1'b0;
    if (w1c && bus_wdata[STAT_FRAME_ERR]) frame_err_d = 1'b0;
    if (fifo_drop) overrun_d   = 1'b1;
    if (frame_set) frame_err_d = 1'b1;
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .din_i   (shift_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    count_ext = 32'(fifo_count);
    count4    = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    status    = '0;
    status[STAT_NOT_EMPTY]           = !fifo_empty;
    status[STAT_FULL]                = fifo_full;
    status[STAT_OVERRUN]             = overrun_q;
    status[STAT_FRAME_ERR]           = frame_err_q;
    status[STAT_COUNT_LSB +: 4]      = count4;
  end

  always_comb begin
    mmio_rdata = '0;
    case (offset)
      REG_DATA:   if (!fifo_empty) mmio_rdata = {24'b0, fifo_head};
      REG_STATUS: mmio_rdata = status;
      default:    mmio_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: serial frames driven at 434 clk/bit,
// expected bytes tracked in a scoreboard queue, register vectors from tables.
module tb_uart_rx_mmio;
  localparam int BIT = 434;
  localparam logic [31:0] BASE = 32'hABCD_E000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_pin;
  logic [31:0] bus_addr;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [31:0] mmio_rdata;
  logic        rx_irq;

  always #10 clk = ~clk;

  uart_rx_mmio dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .bus_addr   (bus_addr),
    .bus_ren    (bus_ren),
    .bus_wen    (bus_wen),
    .bus_wdata  (bus_wdata),
    .mmio_rdata (mmio_rdata),
    .rx_irq     (rx_irq)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] sb_q[$];
  bit m_ovr = 1'b0;
  bit m_ferr = 1'b0;

  typedef struct {
    logic [1:0]  off;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_status;
  } bus_vec_t;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_status;
  } burst_vec_t;

  bus_vec_t   bus_tbl[7];
  burst_vec_t burst_tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  function automatic logic [31:0] model_status();
    int c = sb_q.size();
    return {24'b0, 4'(c), m_ferr, m_ovr, (c == 8), (c != 0)};
  endfunction

  task automatic peek(input logic [1:0] off, output logic [31:0] v);
    bus_addr = BASE | {28'b0, off, 2'b00};
    #1 v = mmio_rdata;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    @(posedge clk);
    #1 bus_addr = BASE | {28'b0, off, 2'b00};
    bus_wen = 1'b1;
    bus_wdata = d;
    @(posedge clk);
    #1 bus_wen = 1'b0;
    if (off == 2'd1) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
    end
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    @(posedge clk);
    #1 bus_addr = BASE;
    bus_ren = 1'b1;
    #1 exp = (sb_q.size() == 0) ? 8'h00 : sb_q.pop_front();
    check(name, mmio_rdata, {24'b0, exp});
    @(posedge clk);
    #1 bus_ren = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_pin = d[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rx_pin = stop;
    repeat (BIT) @(posedge clk);
    #1 rx_pin = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    if (sb_q.size() < 8) sb_q.push_back(d);
    else m_ovr = 1'b1;
    send_frame(d, 1'b1);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  e;

    bus_tbl[0] = '{2'd0, 1'b1, 1'b0, 32'h0,        32'h0, 32'h0};
    bus_tbl[1] = '{2'd1, 1'b1, 1'b0, 32'h0,        32'h0, 32'h0};
    bus_tbl[2] = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h0, 32'h0};
    bus_tbl[3] = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h0, 32'h0};
    bus_tbl[4] = '{2'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0};
    bus_tbl[5] = '{2'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0};
    bus_tbl[6] = '{2'd0, 1'b0, 1'b1, 32'h0000_0055, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      burst_tbl[i].data = 8'(i + 1);
      burst_tbl[i].exp_status = (i < 7) ? {24'b0, 4'(i + 1), 4'h1}
                              : (i == 7) ? 32'h83 : 32'h87;
    end

    rst_n = 1'b0; rx_pin = 1'b1; bus_addr = BASE; bus_ren = 1'b0;
    bus_wen = 1'b0; bus_wdata = 32'h0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", mmio_rdata, 32'h0);
    check("reset_irq", {31'b0, rx_irq}, 32'h0);
    peek(2'd1, v);
    check("reset_status", v, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1 bus_addr = BASE | {28'b0, bus_tbl[i].off, 2'b00};
      bus_ren = bus_tbl[i].ren;
      bus_wen = bus_tbl[i].wen;
      bus_wdata = bus_tbl[i].wdata;
      #1 check($sformatf("busvec%0d_rdata", i), mmio_rdata, bus_tbl[i].exp_rdata);
      @(posedge clk);
      #1 bus_ren = 1'b0;
      bus_wen = 1'b0;
      peek(2'd1, v);
      check($sformatf("busvec%0d_status", i), v, bus_tbl[i].exp_status);
    end

    send_good(8'h55);
    peek(2'd1, v);
    check("b55_status", v, 32'h11);
    check("b55_irq_high", {31'b0, rx_irq}, 32'h1);
    pop_check("b55_data");
    check("b55_irq_lag", {31'b0, rx_irq}, 32'h1);
    peek(2'd1, v);
    check("b55_status_after", v, 32'h0);
    @(posedge clk);
    #1 check("b55_irq_fall", {31'b0, rx_irq}, 32'h0);

    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (100) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (300) @(posedge clk);
    peek(2'd1, v);
    check("glitch_status", v, 32'h0);
    check("glitch_irq", {31'b0, rx_irq}, 32'h0);

    send_frame(8'hA3, 1'b0);
    m_ferr = 1'b1;
    repeat (10) @(posedge clk);
    peek(2'd1, v);
    check("ferr_status", v, 32'h08);
    check("ferr_model", v, model_status());
    wr(2'd1, 32'h8);
    peek(2'd1, v);
    check("ferr_cleared", v, 32'h0);

    for (int i = 0; i < 9; i++) begin
      send_good(burst_tbl[i].data);
      peek(2'd1, v);
      check($sformatf("burst%0d_status", i), v, burst_tbl[i].exp_status);
    end
    wr(2'd1, 32'h4);
    peek(2'd1, v);
    check("ovr_cleared", v, 32'h83);

    // DATA read lands in the exact cycle the receiver pushes 0x0A.
    fork
      send_frame(8'h0A, 1'b1);
      begin
        @(posedge clk);
        repeat (4126) @(posedge clk);
        #1 bus_addr = BASE;
        bus_ren = 1'b1;
        #1 e = sb_q.pop_front();
        check("simul_data", mmio_rdata, {24'b0, e});
        sb_q.push_back(8'h0A);
        @(posedge clk);
        #1 bus_ren = 1'b0;
      end
    join
    peek(2'd1, v);
    check("simul_status", v, 32'h83);
    check("simul_model", v, model_status());

    for (int i = 0; i < 7; i++) pop_check($sformatf("drain%0d", i));
    peek(2'd1, v);
    check("drain_status", v, 32'h11);

    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk);
        repeat (5 * BIT + 200) @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        peek(2'd1, v);
        check("rst_status", v, 32'h0);
        check("rst_irq", {31'b0, rx_irq}, 32'h0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    peek(2'd1, v);
    check("post_rst_status", v, 32'h0);
    send_good(8'h3C);
    peek(2'd1, v);
    check("b3c_status", v, 32'h11);
    pop_check("b3c_data");
    peek(2'd1, v);
    check("b3c_status_after", v, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
